hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding controller for the pipelined RISC-V core, used as the successor of the fixed 3-source forwarder and load-use stall logic in the CPU top.
- Tracks in-flight register writers in an internal scoreboard shift register covering FWD_DEPTH post-decode stages.
- Produces bypassed operands for the decode-stage instruction, handles multi-cycle load latency, generates stall and flush controls on redirect, and keeps a stall performance counter.
- Sits between ID and EXE; the CPU top feeds it per-stage result buses.

Parameters:
- XLEN, 32, operand/data width.
- RA_W, 5, register address width.
- FWD_DEPTH, 3, number of tracked stages after ID (index 0 = EXE output, 1 = MEM output, 2 = WB register); range 1..6.
- LOAD_LAT, 1, scoreboard index at which load data first becomes valid; range 0..FWD_DEPTH-1.
- REDIR_STAGE, 1, scoreboard index of the instruction that asserts redirect; range 0..FWD_DEPTH-2.
- CNT_W, 16, stall counter width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- id_valid  input  1  decode stage holds a valid instruction.
- id_rs1, id_rs2  input  RA_W  source registers of the decode instruction.
- id_use_rs1, id_use_rs2  input  1  source is actually read.
- id_rd  input  RA_W  destination register.
- id_we  input  1  instruction writes rd.
- id_load  input  1  instruction is any load (lw/lh/lhu/lb/lbu).
- rf_data1, rf_data2  input  XLEN  register file read data.
- stage_data  input  FWD_DEPTH*XLEN  result of scoreboard entry i in bits [i*XLEN +: XLEN].
- redirect  input  1  taken branch or jump resolved at REDIR_STAGE.
- fwd_data1, fwd_data2  output  XLEN  bypassed operands.
- fwd_sel1, fwd_sel2  output  3  source select: 0 = register file, i+1 = entry i.
- stall  output  1  hold PC and IF/ID, insert a bubble.
- flush_id  output  1  kill the decode instruction.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- **Scoreboard:** FWD_DEPTH entries of {v, we, rd, ld}, advancing every cycle.
  - entry[i] <= entry[i-1] for i ≥ 1.
  - entry[0] <= {1, id_we && id_rd != 0, id_rd, id_load} when id_valid && !stall && !redirect; otherwise all zero (bubble).
  - The entry leaving index FWD_DEPTH-1 is dropped, because the register file now holds its value.
- **Match:** entry i matches source s when v && we && rd == s && s != 0 && use_s.
  - The youngest match (lowest index) wins.
  - With no match, select the register file.
- **Forwarding:** combinational, zero latency. fwd_data = stage_data[i] of the winning entry, else rf_data.
- **Load-use stall:** stall = id_valid && !redirect && (some winning match for rs1 or rs2 has ld = 1 and i < LOAD_LAT).
  - stall is combinational.
  - Successive bubbles age the load until i reaches LOAD_LAT.
  - With LOAD_LAT = 1 this gives exactly 1 stall cycle for a back-to-back load-use pair. With LOAD_LAT = 2 it gives 2 cycles.
- **Redirect:**
  - flush_id = redirect (combinational).
  - At the clock edge, after the shift, clear entries 0..REDIR_STAGE; these are the younger wrong-path instructions plus the un-inserted ID instruction.
  - The redirecting instruction moves to index REDIR_STAGE+1 and stays valid.
  - Redirect has priority over stall: stall = 0 in any cycle with redirect = 1.
- **Stall counter:** increments by 1 each cycle stall = 1, saturates at all-ones, and never wraps.
- **Reset (asserted, async low):**
  - All entries are cleared and stall_count = 0.
  - Outputs settle combinationally to stall = 0, flush_id = redirect, fwd_sel = 0, fwd_data = rf_data.
  - Reset mid-stall discards the pending load entry; the first cycle after release sees no hazards.
- **x0:** x0 is never forwarded and never causes a stall.
- **Same-register sources:** rs1 == rs2 selects the same source index for both ports.

Test Plan:
- **Back-to-back ALU chain:** add x5 (result 0x11) enters entry 0; next ID reads x5, rf_data1 = 0 -> fwd_sel1 = 1, fwd_data1 = 0x11, stall = 0.
- **Load-use, LOAD_LAT = 1:** lw x6 followed by add x7,x6,x6 -> stall = 1 for exactly 1 cycle, stall_count 0 -> 1. Next cycle fwd_sel1 = fwd_sel2 = 2 and fwd_data equals stage_data[1].
- **LOAD_LAT = 2 build:** same sequence -> stall for 2 consecutive cycles, stall_count = 2, then forward from entry 2 (fwd_sel = 3).
- **Priority and x0:**
  - Entries 0 and 2 both write x8 -> fwd_sel = 1 (youngest).
  - A write to x0 with ID reading x0 -> fwd_sel = 0, stall = 0.
- **Redirect with a pending load-use:** redirect = 1 in the same cycle as a load-use hazard -> stall = 0, flush_id = 1. Next cycle entries 0..1 are invalid; entry 2 is still valid.
- **Reset and saturation:**
  - CNT_W = 4, with 20 forced stall cycles -> stall_count holds at 15.
  - Assert reset asynchronously between clock edges -> stall_count = 0 and stall = 0 immediately.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller between ID and EXE: tracks in-flight writers
// in a shifting scoreboard, bypasses operands, raises load-use stalls and flushes.
module hazard_fwd_unit #(
  parameter int XLEN        = 32,
  parameter int RA_W        = 5,
  parameter int FWD_DEPTH   = 3,
  parameter int LOAD_LAT    = 1,
  parameter int REDIR_STAGE = 1,
  parameter int CNT_W       = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [RA_W-1:0]           id_rs1,
  input  logic [RA_W-1:0]           id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [RA_W-1:0]           id_rd,
  input  logic                      id_we,
  input  logic                      id_load,
  input  logic [XLEN-1:0]           rf_data1,
  input  logic [XLEN-1:0]           rf_data2,
  input  logic [FWD_DEPTH*XLEN-1:0] stage_data,
  input  logic                      redirect,
  output logic [XLEN-1:0]           fwd_data1,
  output logic [XLEN-1:0]           fwd_data2,
  output logic [2:0]                fwd_sel1,
  output logic [2:0]                fwd_sel2,
  output logic                      stall,
  output logic                      flush_id,
  output logic [CNT_W-1:0]          stall_count
);

  // Scoreboard entry i describes the instruction whose result is on stage_data slot i.
  logic [FWD_DEPTH-1:0] sb_v;
  logic [FWD_DEPTH-1:0] sb_we;
  logic [FWD_DEPTH-1:0] sb_ld;
  logic [RA_W-1:0]      sb_rd [FWD_DEPTH];

  logic ld_haz1;
  logic ld_haz2;
  logic id_accept;

  // Scanning oldest to youngest lets the youngest matching entry win.
  always_comb begin
    fwd_sel1  = '0;
    fwd_data1 = rf_data1;
    ld_haz1   = 1'b0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (sb_v[i] && sb_we[i] && (sb_rd[i] == id_rs1) && (id_rs1 != '0) && id_use_rs1) begin
        fwd_sel1  = 3'(i + 1);
        fwd_data1 = stage_data[i*XLEN +: XLEN];
        ld_haz1   = sb_ld[i] && (i < LOAD_LAT);
      end
    end
  end

  always_comb begin
    fwd_sel2  = '0;
    fwd_data2 = rf_data2;
    ld_haz2   = 1'b0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (sb_v[i] && sb_we[i] && (sb_rd[i] == id_rs2) && (id_rs2 != '0) && id_use_rs2) begin
        fwd_sel2  = 3'(i + 1);
        fwd_data2 = stage_data[i*XLEN +: XLEN];
        ld_haz2   = sb_ld[i] && (i < LOAD_LAT);
      end
    end
  end

  // Handshake: id_valid qualifies the ID instruction and !stall acts as its ready;
  // it enters the scoreboard only on id_valid && !stall && !redirect, else a bubble.
  assign stall     = id_valid && !redirect && (ld_haz1 || ld_haz2);
  assign flush_id  = redirect;
  assign id_accept = id_valid && !stall && !redirect;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb_v        <= '0;
      sb_we       <= '0;
      sb_ld       <= '0;
      stall_count <= '0;
      for (int i = 0; i < FWD_DEPTH; i++) sb_rd[i] <= '0;
    end else begin
      sb_v[0]  <= id_accept;
      sb_we[0] <= id_accept && id_we && (id_rd != '0);
      sb_ld[0] <= id_accept && id_load;
      sb_rd[0] <= id_accept ? id_rd : '0;
      // Wrong-path entries younger than the redirecting instruction are dropped.
      for (int i = 1; i < FWD_DEPTH; i++) begin
        if (redirect && (i <= REDIR_STAGE)) begin
          sb_v[i]  <= 1'b0;
          sb_we[i] <= 1'b0;
          sb_ld[i] <= 1'b0;
          sb_rd[i] <= '0;
        end else begin
          sb_v[i]  <= sb_v[i-1];
          sb_we[i] <= sb_we[i-1];
          sb_ld[i] <= sb_ld[i-1];
          sb_rd[i] <= sb_rd[i-1];
        end
      end
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: default build plus a LOAD_LAT=2 / CNT_W=4 build.
// Expected words are {sel1, sel2, stall, flush_id, data1, data2}.
module tb_hazard_fwd_unit;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int DEPTH = 3;
  localparam logic [31:0] D0 = 32'h0000_0011;
  localparam logic [31:0] D1 = 32'h0000_0022;
  localparam logic [31:0] D2 = 32'h0000_0033;

  logic clock, reset;

  logic              id_valid, id_use_rs1, id_use_rs2, id_we, id_load, redirect;
  logic [RA_W-1:0]   id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   rf_data1, rf_data2, fwd_data1, fwd_data2;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic [2:0]        fwd_sel1, fwd_sel2;
  logic              stall, flush_id;
  logic [15:0]       stall_count;

  logic              b_valid, b_use1, b_use2, b_we, b_ld, b_redirect;
  logic [RA_W-1:0]   b_rs1, b_rs2, b_rd;
  logic [XLEN-1:0]   b_rf1, b_rf2, b_data1, b_data2;
  logic [2:0]        b_sel1, b_sel2;
  logic              b_stall, b_flush;
  logic [3:0]        b_stall_count;

  int n_checks = 0;
  int n_fail = 0;
  logic [71:0] exp_q[$];
  logic [71:0] exp_w, got_w;

  hazard_fwd_unit dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .stage_data(stage_data),
    .redirect(redirect),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall(stall), .flush_id(flush_id), .stall_count(stall_count)
  );

  hazard_fwd_unit #(.LOAD_LAT(2), .CNT_W(4)) dut2 (
    .clock(clock), .reset(reset),
    .id_valid(b_valid), .id_rs1(b_rs1), .id_rs2(b_rs2),
    .id_use_rs1(b_use1), .id_use_rs2(b_use2),
    .id_rd(b_rd), .id_we(b_we), .id_load(b_ld),
    .rf_data1(b_rf1), .rf_data2(b_rf2), .stage_data(stage_data),
    .redirect(b_redirect),
    .fwd_data1(b_data1), .fwd_data2(b_data2),
    .fwd_sel1(b_sel1), .fwd_sel2(b_sel2),
    .stall(b_stall), .flush_id(b_flush), .stall_count(b_stall_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at 200000, required finish earlier");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [71:0] pack_exp(input int s1, input int s2, input int st, input int fl,
                                           input logic [31:0] d1, input logic [31:0] d2);
    return {3'(s1), 3'(s2), 1'(st), 1'(fl), d1, d2};
  endfunction

  task automatic drive_id(input int v, input int rs1, input int rs2, input int u1, input int u2,
                          input int rd, input int we, input int ld);
    id_valid = 1'(v); id_rs1 = RA_W'(rs1); id_rs2 = RA_W'(rs2);
    id_use_rs1 = 1'(u1); id_use_rs2 = 1'(u2);
    id_rd = RA_W'(rd); id_we = 1'(we); id_load = 1'(ld);
  endtask

  task automatic drive_b(input int v, input int rs1, input int rs2, input int u1, input int u2,
                         input int rd, input int we, input int ld);
    b_valid = 1'(v); b_rs1 = RA_W'(rs1); b_rs2 = RA_W'(rs2);
    b_use1 = 1'(u1); b_use2 = 1'(u2);
    b_rd = RA_W'(rd); b_we = 1'(we); b_ld = 1'(ld);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    redirect = 1'b0;
    repeat (n) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_id(1, 6, 6, 1, 1, 7, 1, 1);
    rf_data1 = 32'hA5A5_0001; rf_data2 = 32'hA5A5_0002;
    redirect = 1'b1;
    #2;
    exp_q.push_back(pack_exp(0, 0, 0, 1, 32'hA5A5_0001, 32'hA5A5_0002));
    exp_w = exp_q.pop_front();
    got_w = {fwd_sel1, fwd_sel2, stall, flush_id, fwd_data1, fwd_data2};
    n_checks++;
    if (got_w !== exp_w) begin
      n_fail++;
      $display("FAIL reset_outputs_redir: got %h, expected %h", got_w, exp_w);
    end
    redirect = 1'b0;
    #1;
    exp_q.push_back(pack_exp(0, 0, 0, 0, 32'hA5A5_0001, 32'hA5A5_0002));
    exp_w = exp_q.pop_front();
    got_w = {fwd_sel1, fwd_sel2, stall, flush_id, fwd_data1, fwd_data2};
    n_checks++;
    if (got_w !== exp_w) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected %h", got_w, exp_w);
    end
    n_checks++;
    if (stall_count !== 16'd0 || b_stall_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d/%0d, expected 0/0", stall_count, b_stall_count);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu_chain();
    idle(3);
    rf_data1 = '0; rf_data2 = '0;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin drive_id(1, 1, 2, 1, 1, 5, 1, 0);  exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 0)); end
        1: begin drive_id(1, 5, 0, 1, 1, 9, 1, 0);  exp_q.push_back(pack_exp(1, 0, 0, 0, D0, 0)); end
        2: begin drive_id(1, 9, 5, 1, 1, 10, 1, 0); exp_q.push_back(pack_exp(1, 2, 0, 0, D0, D1)); end
        3: begin drive_id(1, 5, 9, 1, 1, 11, 1, 0); exp_q.push_back(pack_exp(3, 2, 0, 0, D2, D1)); end
        default: begin drive_id(1, 10, 11, 0, 0, 0, 0, 0); exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 0)); end
      endcase
      @(negedge clock);
      exp_w = exp_q.pop_front();
      got_w = {fwd_sel1, fwd_sel2, stall, flush_id, fwd_data1, fwd_data2};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL alu_chain_%0d: got %h, expected %h", k, got_w, exp_w);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    idle(3);
    rf_data1 = 32'hF1; rf_data2 = 32'hF2;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin drive_id(1, 1, 0, 1, 0, 6, 1, 1); exp_q.push_back(pack_exp(0, 0, 0, 0, 32'hF1, 32'hF2)); end
        1: begin drive_id(1, 6, 6, 1, 1, 7, 1, 0); exp_q.push_back(pack_exp(1, 1, 1, 0, D0, D0)); end
        default: exp_q.push_back(pack_exp(2, 2, 0, 0, D1, D1));
      endcase
      @(negedge clock);
      exp_w = exp_q.pop_front();
      got_w = {fwd_sel1, fwd_sel2, stall, flush_id, fwd_data1, fwd_data2};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL load_use_%0d: got %h, expected %h", k, got_w, exp_w);
      end
      tick();
    end
    n_checks++;
    if (stall_count !== 16'd1) begin
      n_fail++;
      $display("FAIL load_use_count: got %0d, expected 1", stall_count);
    end
  endtask

  task automatic test_priority_x0();
    idle(3);
    drive_id(1, 0, 0, 0, 0, 8, 1, 0); tick();
    drive_id(1, 0, 0, 0, 0, 3, 1, 0); tick();
    drive_id(1, 0, 0, 0, 0, 8, 1, 0); tick();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        drive_id(1, 8, 8, 1, 1, 0, 1, 1);
        exp_q.push_back(pack_exp(1, 1, 0, 0, D0, D0));
      end else begin
        drive_id(1, 0, 0, 1, 1, 0, 0, 0);
        exp_q.push_back(pack_exp(0, 0, 0, 0, 32'hF1, 32'hF2));
      end
      @(negedge clock);
      exp_w = exp_q.pop_front();
      got_w = {fwd_sel1, fwd_sel2, stall, flush_id, fwd_data1, fwd_data2};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL priority_x0_%0d: got %h, expected %h", k, got_w, exp_w);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    idle(3);
    drive_id(1, 1, 0, 1, 0, 12, 1, 0); tick();
    drive_id(1, 1, 0, 1, 0, 6, 1, 1);  tick();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        drive_id(1, 6, 6, 1, 1, 7, 1, 0);
        redirect = 1'b1;
        exp_q.push_back(pack_exp(1, 1, 0, 1, D0, D0));
      end else begin
        redirect = 1'b0;
        drive_id(1, 6, 12, 1, 1, 13, 1, 0);
        exp_q.push_back(pack_exp(0, 3, 0, 0, 32'hF1, D2));
      end
      @(negedge clock);
      exp_w = exp_q.pop_front();
      got_w = {fwd_sel1, fwd_sel2, stall, flush_id, fwd_data1, fwd_data2};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL redirect_%0d: got %h, expected %h", k, got_w, exp_w);
      end
      tick();
    end
    n_checks++;
    if (stall_count !== 16'd1) begin
      n_fail++;
      $display("FAIL redirect_count: got %0d, expected 1", stall_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle(3);
    drive_id(1, 1, 0, 1, 0, 6, 1, 1); tick();
    drive_id(1, 6, 6, 1, 1, 7, 1, 0);
    exp_q.push_back(pack_exp(1, 1, 1, 0, D0, D0));
    @(negedge clock);
    exp_w = exp_q.pop_front();
    got_w = {fwd_sel1, fwd_sel2, stall, flush_id, fwd_data1, fwd_data2};
    n_checks++;
    if (got_w !== exp_w) begin
      n_fail++;
      $display("FAIL mid_stall_pre: got %h, expected %h", got_w, exp_w);
    end
    #2 reset = 1'b0;
    exp_q.push_back(pack_exp(0, 0, 0, 0, 32'hF1, 32'hF2));
    #1;
    exp_w = exp_q.pop_front();
    got_w = {fwd_sel1, fwd_sel2, stall, flush_id, fwd_data1, fwd_data2};
    n_checks++;
    if (got_w !== exp_w || stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_stall_async: got %h cnt %0d, expected %h cnt 0", got_w, stall_count, exp_w);
    end
    #1 reset = 1'b1;
    tick();
    exp_q.push_back(pack_exp(0, 0, 0, 0, 32'hF1, 32'hF2));
    @(negedge clock);
    exp_w = exp_q.pop_front();
    got_w = {fwd_sel1, fwd_sel2, stall, flush_id, fwd_data1, fwd_data2};
    n_checks++;
    if (got_w !== exp_w || stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_stall_post: got %h cnt %0d, expected %h cnt 0", got_w, stall_count, exp_w);
    end
    tick();
  endtask

  task automatic test_load_lat2_saturation();
    drive_b(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin drive_b(1, 1, 0, 1, 0, 6, 1, 1); exp_q.push_back(pack_exp(0, 0, 0, 0, 32'hB1, 32'hB2)); end
        1: begin drive_b(1, 6, 6, 1, 1, 7, 1, 0); exp_q.push_back(pack_exp(1, 1, 1, 0, D0, D0)); end
        2: exp_q.push_back(pack_exp(2, 2, 1, 0, D1, D1));
        default: exp_q.push_back(pack_exp(3, 3, 0, 0, D2, D2));
      endcase
      @(negedge clock);
      exp_w = exp_q.pop_front();
      got_w = {b_sel1, b_sel2, b_stall, b_flush, b_data1, b_data2};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL lat2_%0d: got %h, expected %h", k, got_w, exp_w);
      end
      tick();
    end
    n_checks++;
    if (b_stall_count !== 4'd2) begin
      n_fail++;
      $display("FAIL lat2_count: got %0d, expected 2", b_stall_count);
    end
    for (int it = 0; it < 9; it++) begin
      drive_b(1, 1, 0, 1, 0, 6, 1, 1);
      tick();
      drive_b(1, 6, 6, 1, 1, 7, 1, 0);
      @(negedge clock);
      n_checks++;
      if (b_stall !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_stall_%0d: got %b, expected 1", it, b_stall);
      end
      repeat (3) tick();
    end
    @(negedge clock);
    n_checks++;
    if (b_stall_count !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_count: got %0d, expected 15", b_stall_count);
    end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    redirect = 1'b0;
    b_redirect = 1'b0;
    stage_data = {D2, D1, D0};
    rf_data1 = '0; rf_data2 = '0;
    b_rf1 = 32'hB1; b_rf2 = 32'hB2;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_chain();
    test_load_use();
    test_priority_x0();
    test_redirect();
    test_reset_mid_stall();
    test_load_lat2_saturation();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
